// File: rtl/sample_bus_sequencer.sv
// Round-robin sampler for the shared wired-OR sample bus: strobes each table
// channel in turn, captures the bus after a fixed latency and pushes it to the FIFO.
module sample_bus_sequencer #(
  parameter int POSITION       = 242,
  parameter int TABLE_DEPTH    = 16,
  parameter int SAMPLE_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_bus_en,
  input  logic        cmd_bus_wr,
  input  logic [15:0] cmd_bus_addr,
  input  logic [31:0] cmd_bus_data,
  output logic [7:0]  channel_select,
  output logic        output_sample,
  input  logic [31:0] sample_data,
  output logic [31:0] fifo_din,
  output logic        fifo_wr_en,
  input  logic        fifo_full,
  output logic        running,
  output logic [15:0] overflow_count
);

  localparam int IW = $clog2(TABLE_DEPTH);
  localparam int CW = IW + 1;
  localparam int LW = $clog2(SAMPLE_LATENCY + 1);

  localparam logic [7:0] OP_ADD    = 8'h01;
  localparam logic [7:0] OP_CLEAR  = 8'h02;
  localparam logic [7:0] OP_START  = 8'h03;
  localparam logic [7:0] OP_STOP   = 8'h04;
  localparam logic [7:0] OP_CLRCNT = 8'h05;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SELECT  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_PUSH    = 3'd4;

  logic [7:0]    chan_table [TABLE_DEPTH];
  logic [CW-1:0] count;
  logic [IW-1:0] index;
  logic [IW-1:0] index_next;
  logic [2:0]    state;
  logic [LW-1:0] wait_cnt;
  logic [7:0]    chan;
  logic          run_q;
  logic [15:0]   ovf_q;
  logic [31:0]   din_q;

  logic       cmd_hit;
  logic [7:0] opcode;
  logic [7:0] arg;
  logic       do_add;
  logic       do_clear;
  logic       do_start;
  logic       do_stop;
  logic       do_clrcnt;
  logic       table_room;
  logic       unused_cmd_bits;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [IW-1:0] wrap_index(input logic [IW-1:0] idx,
                                               input logic [CW-1:0] cnt);
    logic [CW-1:0] nxt;
    nxt = {1'b0, idx} + CW'(1);
    return (nxt >= cnt) ? '0 : nxt[IW-1:0];
  endfunction

  assign cmd_hit    = cmd_bus_en && cmd_bus_wr && (cmd_bus_addr == 16'(POSITION));
  assign opcode     = cmd_bus_data[31:24];
  assign arg        = cmd_bus_data[7:0];
  assign do_add     = cmd_hit && (opcode == OP_ADD);
  assign do_clear   = cmd_hit && (opcode == OP_CLEAR);
  assign do_start   = cmd_hit && (opcode == OP_START);
  assign do_stop    = cmd_hit && (opcode == OP_STOP);
  assign do_clrcnt  = cmd_hit && (opcode == OP_CLRCNT);
  assign table_room = (count < CW'(TABLE_DEPTH));
  assign index_next = wrap_index(index, count);

  assign unused_cmd_bits = ^cmd_bus_data[23:8];

  // Table storage carries no reset; count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (do_add && table_room) begin
      chan_table[count[IW-1:0]] <= arg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      index    <= '0;
      state    <= S_IDLE;
      wait_cnt <= '0;
      chan     <= 8'hFF;
      run_q    <= 1'b0;
      ovf_q    <= 16'd0;
      din_q    <= 32'd0;
    end else begin
      if (do_clear) begin
        count <= '0;
      end else if (do_add && table_room) begin
        count <= count + CW'(1);
      end

      if (do_clear || do_stop) begin
        run_q <= 1'b0;
      end else if (do_start && (count != '0)) begin
        run_q <= 1'b1;
      end

      // CLRCNT takes priority over a drop counted in the same cycle.
      if (do_clrcnt) begin
        ovf_q <= 16'd0;
      end else if ((state == S_PUSH) && fifo_full) begin
        ovf_q <= sat_inc(ovf_q);
      end

      case (state)
        S_IDLE: begin
          if (run_q) begin
            state <= S_SELECT;
            chan  <= chan_table[index];
          end
        end
        S_SELECT: begin
          state    <= S_WAIT;
          wait_cnt <= LW'(SAMPLE_LATENCY - 1);
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state <= S_CAPTURE;
          end else begin
            wait_cnt <= wait_cnt - LW'(1);
          end
        end
        S_CAPTURE: begin
          din_q <= sample_data;
          state <= S_PUSH;
        end
        S_PUSH: begin
          if (run_q) begin
            state <= S_SELECT;
            chan  <= chan_table[index_next];
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // The channel for the next slot is latched above from index_next, so
      // CLEAR only has to force the stored index back to the table start.
      if (do_clear) begin
        index <= '0;
      end else if (state == S_PUSH) begin
        index <= index_next;
      end
    end
  end

  assign channel_select = (state == S_IDLE) ? 8'hFF : chan;
  assign output_sample  = (state == S_SELECT);
  assign fifo_wr_en     = (state == S_PUSH) && !fifo_full;
  assign fifo_din       = din_q;
  assign running        = run_q;
  assign overflow_count = ovf_q;

endmodule

// File: tb/tb_sample_bus_sequencer.sv
// Directed bench for sample_bus_sequencer: one task per scenario, inline checks.
module tb_sample_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_bus_en;
  logic        cmd_bus_wr;
  logic [15:0] cmd_bus_addr;
  logic [31:0] cmd_bus_data;
  logic [7:0]  channel_select;
  logic        output_sample;
  logic [31:0] sample_data;
  logic [31:0] fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full;
  logic        running;
  logic [15:0] overflow_count;

  int n_cmp = 0;
  int n_bad = 0;

  sample_bus_sequencer #(
    .POSITION(242), .TABLE_DEPTH(16), .SAMPLE_LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_bus_en(cmd_bus_en), .cmd_bus_wr(cmd_bus_wr),
    .cmd_bus_addr(cmd_bus_addr), .cmd_bus_data(cmd_bus_data),
    .channel_select(channel_select), .output_sample(output_sample),
    .sample_data(sample_data), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .running(running), .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;

  // Each channel answers with a recognisable word carrying its own number.
  assign sample_data = (channel_select == 8'hFF) ? 32'h0 : {16'hC0DE, 8'h00, channel_select};

  task automatic cmd(input logic [15:0] addr, input logic [7:0] op, input logic [7:0] a);
    cmd_bus_en   = 1'b1;
    cmd_bus_wr   = 1'b1;
    cmd_bus_addr = addr;
    cmd_bus_data = {op, 16'h0000, a};
    @(negedge clk);
    cmd_bus_en   = 1'b0;
    cmd_bus_wr   = 1'b0;
    cmd_bus_data = 32'h0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if (channel_select !== 8'hFF) begin n_bad++; $display("FAIL reset_chan: got %h want ff", channel_select); end
    n_cmp++; if (output_sample !== 1'b0) begin n_bad++; $display("FAIL reset_strobe: got %b want 0", output_sample); end
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr: got %b want 0", fifo_wr_en); end
    n_cmp++; if (fifo_din !== 32'h0) begin n_bad++; $display("FAIL reset_din: got %h want 0", fifo_din); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %b want 0", running); end
    n_cmp++; if (overflow_count !== 16'h0) begin n_bad++; $display("FAIL reset_ovf: got %h want 0", overflow_count); end
  endtask

  task automatic test_round_robin;
    int k;
    logic [7:0] ch;
    do_reset();
    cmd(16'd242, 8'h01, 8'd3);
    cmd(16'd241, 8'h01, 8'h55);
    cmd(16'd242, 8'h09, 8'h66);
    cmd(16'd242, 8'h01, 8'd7);
    cmd(16'd242, 8'h03, 8'h00);
    k = 0;
    while (output_sample !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    n_cmp++; if (output_sample !== 1'b1) begin n_bad++; $display("FAIL rr_first_strobe: got %b want 1", output_sample); end
    for (int s = 0; s < 4; s++) begin
      ch = (s % 2 == 0) ? 8'd3 : 8'd7;
      n_cmp++; if (channel_select !== ch) begin n_bad++; $display("FAIL rr_chan slot %0d: got %0d want %0d", s, channel_select, ch); end
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        if (c < 4) begin
          n_cmp++; if ({output_sample, fifo_wr_en, channel_select} !== {2'b00, ch}) begin
            n_bad++; $display("FAIL rr_hold slot %0d c%0d: got %b%b/%0d want 00/%0d", s, c, output_sample, fifo_wr_en, channel_select, ch);
          end
        end else begin
          n_cmp++; if (fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL rr_wr slot %0d: got %b want 1", s, fifo_wr_en); end
          n_cmp++; if (fifo_din !== {16'hC0DE, 8'h00, ch}) begin n_bad++; $display("FAIL rr_din slot %0d: got %h want %h", s, fifo_din, {16'hC0DE, 8'h00, ch}); end
        end
      end
      @(negedge clk);
      n_cmp++; if (output_sample !== 1'b1) begin n_bad++; $display("FAIL rr_period slot %0d: got %b want 1", s, output_sample); end
    end
    cmd(16'd242, 8'h04, 8'h00);
    repeat (8) @(negedge clk);
    n_cmp++; if ({running, channel_select} !== {1'b0, 8'hFF}) begin n_bad++; $display("FAIL rr_stop: got %b/%h want 0/ff", running, channel_select); end
  endtask

  task automatic test_overflow;
    int k;
    do_reset();
    cmd(16'd242, 8'h01, 8'd5);
    fifo_full = 1'b1;
    cmd(16'd242, 8'h03, 8'h00);
    k = 0;
    while (output_sample !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    n_cmp++; if (output_sample !== 1'b1) begin n_bad++; $display("FAIL ovf_first_strobe: got %b want 1", output_sample); end
    for (int s = 0; s < 3; s++) begin
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL ovf_nowrite slot %0d c%0d: got %b want 0", s, c, fifo_wr_en); end
      end
      @(negedge clk);
    end
    n_cmp++; if (overflow_count !== 16'd3) begin n_bad++; $display("FAIL ovf_count: got %0d want 3", overflow_count); end
    repeat (4) @(negedge clk);
    cmd(16'd242, 8'h05, 8'h00);
    n_cmp++; if (overflow_count !== 16'd0) begin n_bad++; $display("FAIL ovf_clr_wins: got %0d want 0", overflow_count); end
    fifo_full = 1'b0;
    cmd(16'd242, 8'h04, 8'h00);
    repeat (6) @(negedge clk);
    n_cmp++; if ({running, channel_select, overflow_count} !== {1'b0, 8'hFF, 16'd0}) begin
      n_bad++; $display("FAIL ovf_drain: got %b/%h/%0d want 0/ff/0", running, channel_select, overflow_count);
    end
  endtask

  task automatic test_stop_in_wait;
    int k;
    logic seen;
    do_reset();
    cmd(16'd242, 8'h01, 8'd1);
    cmd(16'd242, 8'h01, 8'd2);
    cmd(16'd242, 8'h03, 8'h00);
    k = 0;
    while (output_sample !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    n_cmp++; if (channel_select !== 8'd1) begin n_bad++; $display("FAIL stop_chan: got %0d want 1", channel_select); end
    @(negedge clk);
    cmd(16'd242, 8'h04, 8'h00);
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL stop_running: got %b want 0", running); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL stop_wr: got %b want 1", fifo_wr_en); end
    n_cmp++; if (fifo_din !== 32'hC0DE_0001) begin n_bad++; $display("FAIL stop_din: got %h want c0de0001", fifo_din); end
    @(negedge clk);
    n_cmp++; if (channel_select !== 8'hFF) begin n_bad++; $display("FAIL stop_idle_chan: got %h want ff", channel_select); end
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (output_sample !== 1'b0 || fifo_wr_en !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL stop_quiet: got activity=%b want 0", seen); end
  endtask

  task automatic test_table_full;
    int k;
    logic [7:0] ch;
    do_reset();
    cmd(16'd242, 8'h03, 8'h00);
    repeat (4) @(negedge clk);
    n_cmp++; if ({running, output_sample, channel_select} !== {2'b00, 8'hFF}) begin
      n_bad++; $display("FAIL empty_start: got %b%b/%h want 00/ff", running, output_sample, channel_select);
    end
    for (int i = 0; i < 17; i++) cmd(16'd242, 8'h01, 8'(10 + i));
    cmd(16'd242, 8'h03, 8'h00);
    k = 0;
    while (output_sample !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    for (int s = 0; s < 17; s++) begin
      ch = (s < 16) ? 8'(10 + s) : 8'd10;
      n_cmp++; if ({output_sample, channel_select} !== {1'b1, ch}) begin
        n_bad++; $display("FAIL full_seq slot %0d: got %b/%0d want 1/%0d", s, output_sample, channel_select, ch);
      end
      repeat (5) @(negedge clk);
    end
    cmd(16'd242, 8'h04, 8'h00);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_add_while_running;
    int k;
    logic [7:0] ch;
    do_reset();
    cmd(16'd242, 8'h01, 8'd4);
    cmd(16'd242, 8'h03, 8'h00);
    k = 0;
    while (output_sample !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    n_cmp++; if (channel_select !== 8'd4) begin n_bad++; $display("FAIL addrun_first: got %0d want 4", channel_select); end
    cmd(16'd242, 8'h01, 8'd9);
    repeat (4) @(negedge clk);
    for (int s = 1; s < 4; s++) begin
      ch = (s % 2 == 1) ? 8'd9 : 8'd4;
      n_cmp++; if ({output_sample, channel_select} !== {1'b1, ch}) begin
        n_bad++; $display("FAIL addrun_seq slot %0d: got %b/%0d want 1/%0d", s, output_sample, channel_select, ch);
      end
      repeat (5) @(negedge clk);
    end
    cmd(16'd242, 8'h04, 8'h00);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid_slot;
    int k;
    logic seen;
    do_reset();
    cmd(16'd242, 8'h01, 8'd6);
    cmd(16'd242, 8'h03, 8'h00);
    k = 0;
    while (output_sample !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    n_cmp++; if (channel_select !== 8'd6) begin n_bad++; $display("FAIL midrst_pre: got %0d want 6", channel_select); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({channel_select, output_sample, fifo_wr_en, running} !== {8'hFF, 3'b000}) begin
      n_bad++; $display("FAIL midrst_async: got %h/%b%b%b want ff/000", channel_select, output_sample, fifo_wr_en, running);
    end
    n_cmp++; if (fifo_din !== 32'h0) begin n_bad++; $display("FAIL midrst_din: got %h want 0", fifo_din); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (output_sample !== 1'b0 || fifo_wr_en !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if ({seen, running} !== 2'b00) begin n_bad++; $display("FAIL midrst_after: got activity=%b running=%b want 0/0", seen, running); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    cmd_bus_en   = 1'b0;
    cmd_bus_wr   = 1'b0;
    cmd_bus_addr = 16'h0;
    cmd_bus_data = 32'h0;
    fifo_full    = 1'b0;
    test_reset();
    test_round_robin();
    test_overflow();
    test_stop_in_wait();
    test_table_full();
    test_add_while_running();
    test_reset_mid_slot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
